// File: rtl/spectrum_peak_hold.sv
// spectrum_peak_hold: per-bin smoothing, peak hold with timed decay and
// dominant-bin search over one magnitude frame. Bins are walked serially,
// one per clock, through a single shared arithmetic datapath.
// Optional build macro: SPECTRUM_OVERRUN_CNT_EN adds an 8-bit saturating
// count of frames dropped while busy (output overrun_cnt).
module spectrum_peak_hold #(
    parameter int unsigned NBINS       = 8,
    parameter int unsigned MAG_W       = 13,
    parameter int unsigned DECAY_SHIFT = 4,
    parameter int unsigned HOLD_FRAMES = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     mag_valid,
    input  logic [MAG_W-1:0]         mag        [NBINS],
    output logic [MAG_W-1:0]         smooth     [NBINS],
    output logic [MAG_W-1:0]         peak       [NBINS],
    output logic [$clog2(NBINS)-1:0] max_bin,
    output logic [MAG_W-1:0]         max_mag,
    output logic                     frame_done,
    output logic                     busy
`ifdef SPECTRUM_OVERRUN_CNT_EN
    ,
    output logic [7:0]               overrun_cnt
`endif
);

    localparam int unsigned IDX_W = $clog2(NBINS);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e state_q, state_d;

    logic [MAG_W-1:0] snap_q [NBINS];
    logic [7:0]       hold_q [NBINS];
    logic [IDX_W-1:0] idx_q;
    logic [MAG_W-1:0] rmax_q;
    logic [IDX_W-1:0] rbin_q;

    logic                    last_bin;
    logic [MAG_W-1:0]        cur_snap, cur_smooth, cur_peak;
    logic [7:0]              cur_hold;
    logic signed [MAG_W:0]   delta, step, smooth_sum;
    logic [MAG_W-1:0]        smooth_new, peak_new, pk_dec;
    logic [7:0]              hold_new;
    logic                    take_max;
    logic [MAG_W-1:0]        rmax_next;
    logic [IDX_W-1:0]        rbin_next;

    assign last_bin   = (idx_q == IDX_W'(NBINS - 1));
    assign cur_snap   = snap_q[idx_q];
    assign cur_smooth = smooth[idx_q];
    assign cur_peak   = peak[idx_q];
    assign cur_hold   = hold_q[idx_q];

    // Smoothing step: move 1/2^k of the gap, but at least one LSB so a constant
    // input is reached exactly instead of stalling short of it.
    always_comb begin
        delta = $signed({1'b0, cur_snap}) - $signed({1'b0, cur_smooth});
        step  = delta >>> DECAY_SHIFT;
        if (step == '0 && delta != '0) begin
            step = delta[MAG_W] ? {(MAG_W + 1){1'b1}} : {{MAG_W{1'b0}}, 1'b1};
        end
        // |step| <= |delta|, so the sum stays within 0..2^MAG_W-1.
        smooth_sum = $signed({1'b0, cur_smooth}) + step;
        smooth_new = MAG_W'(smooth_sum);
    end

    // Peak hold: capture and re-arm hold on a new peak, else count hold down, then decay.
    always_comb begin
        pk_dec   = cur_peak >> DECAY_SHIFT;
        peak_new = cur_peak;
        hold_new = cur_hold;
        if (cur_snap >= cur_peak) begin
            peak_new = cur_snap;
            hold_new = 8'(HOLD_FRAMES);
        end else if (cur_hold != 8'd0) begin
            hold_new = cur_hold - 8'd1;
        end else if (pk_dec == '0) begin
            // cur_peak > cur_snap >= 0 here, so the peak is never zero.
            peak_new = cur_peak - {{(MAG_W - 1){1'b0}}, 1'b1};
        end else begin
            peak_new = cur_peak - pk_dec;
        end
    end

    // Running maximum; strict compare keeps the lowest index on ties.
    always_comb begin
        take_max  = (cur_snap > rmax_q);
        rmax_next = take_max ? cur_snap : rmax_q;
        rbin_next = take_max ? idx_q : rbin_q;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (mag_valid) state_d = StScan;
            StScan:  if (last_bin) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: busy spans SCAN and DONE, frame_done is the DONE cycle.
    always_comb begin
        busy       = (state_q != StIdle);
        frame_done = (state_q == StDone);
    end

    // Datapath: capture in IDLE, update one bin per SCAN cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NBINS); i++) begin
                snap_q[i] <= '0;
                hold_q[i] <= '0;
                smooth[i] <= '0;
                peak[i]   <= '0;
            end
            idx_q   <= '0;
            rmax_q  <= '0;
            rbin_q  <= '0;
            max_bin <= '0;
            max_mag <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    rmax_q <= '0;
                    rbin_q <= '0;
                    idx_q  <= '0;
                    if (mag_valid) begin
                        for (int i = 0; i < int'(NBINS); i++) begin
                            snap_q[i] <= mag[i];
                        end
                    end
                end
                StScan: begin
                    smooth[idx_q] <= smooth_new;
                    peak[idx_q]   <= peak_new;
                    hold_q[idx_q] <= hold_new;
                    rmax_q        <= rmax_next;
                    rbin_q        <= rbin_next;
                    idx_q         <= idx_q + IDX_W'(1);
                    // Publish the winner on entry to DONE so it is valid with frame_done.
                    if (last_bin) begin
                        max_bin <= rbin_next;
                        max_mag <= rmax_next;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SPECTRUM_OVERRUN_CNT_EN
    // Saturating count of strobes that arrive while a frame is in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun_cnt <= 8'd0;
        end else if (mag_valid && state_q != StIdle && overrun_cnt != 8'hFF) begin
            overrun_cnt <= overrun_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_spectrum_peak_hold.sv
// Self-checking bench for spectrum_peak_hold: a frame model pushes expected
// results to a scoreboard; a monitor pops and compares on every frame_done.
module tb_spectrum_peak_hold;

    localparam int NB   = 8;
    localparam int MW   = 13;
    localparam int DS   = 4;
    localparam int HOLD = 16;

    typedef struct packed {
        logic [NB-1:0][MW-1:0] sm;
        logic [NB-1:0][MW-1:0] pk;
        logic [2:0]            bin;
        logic [MW-1:0]         mx;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          mag_valid = 1'b0;
    logic [MW-1:0] mag    [NB];
    logic [MW-1:0] smooth [NB];
    logic [MW-1:0] peak   [NB];
    logic [2:0]    max_bin;
    logic [MW-1:0] max_mag;
    logic          frame_done;
    logic          busy;
`ifdef SPECTRUM_OVERRUN_CNT_EN
    logic [7:0]    overrun_cnt;
`endif

    spectrum_peak_hold #(
        .NBINS(NB), .MAG_W(MW), .DECAY_SHIFT(DS), .HOLD_FRAMES(HOLD)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .mag_valid  (mag_valid),
        .mag        (mag),
        .smooth     (smooth),
        .peak       (peak),
        .max_bin    (max_bin),
        .max_mag    (max_mag),
        .frame_done (frame_done),
        .busy       (busy)
`ifdef SPECTRUM_OVERRUN_CNT_EN
        ,
        .overrun_cnt(overrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   done_cnt = 0;
    exp_t sb[$];
    int   m_sm [NB];
    int   m_pk [NB];
    int   m_hold [NB];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            m_sm[i] = 0; m_pk[i] = 0; m_hold[i] = 0;
        end
        sb.delete();
    endtask

    // Apply one frame of the current mag to the model and queue the expectation.
    task automatic model_push();
        exp_t e;
        int d, st, dd, rmax, rbin;
        rmax = 0; rbin = 0;
        for (int i = 0; i < NB; i++) begin
            d  = int'(mag[i]) - m_sm[i];
            st = d >>> DS;
            if (st == 0 && d != 0) st = (d > 0) ? 1 : -1;
            m_sm[i] += st;
            if (int'(mag[i]) >= m_pk[i]) begin
                m_pk[i] = int'(mag[i]); m_hold[i] = HOLD;
            end else if (m_hold[i] > 0) begin
                m_hold[i]--;
            end else begin
                dd = m_pk[i] >> DS;
                m_pk[i] -= (dd == 0 && m_pk[i] != 0) ? 1 : dd;
            end
            if (int'(mag[i]) > rmax) begin rmax = int'(mag[i]); rbin = i; end
            e.sm[i] = MW'(m_sm[i]);
            e.pk[i] = MW'(m_pk[i]);
        end
        e.bin = 3'(rbin);
        e.mx  = MW'(rmax);
        sb.push_back(e);
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && frame_done) begin
            done_cnt++;
            check("sb_nonempty", int'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                for (int i = 0; i < NB; i++) begin
                    check($sformatf("smooth[%0d]", i), int'(smooth[i]), int'(e.sm[i]));
                    check($sformatf("peak[%0d]", i), int'(peak[i]), int'(e.pk[i]));
                end
                check("max_bin", int'(max_bin), int'(e.bin));
                check("max_mag", int'(max_mag), int'(e.mx));
            end
        end
    end

    task automatic set_all(input int v);
        for (int i = 0; i < NB; i++) mag[i] = MW'(v);
    endtask

    // One-cycle strobe; returns at the negedge of cycle 1 after the capture edge.
    task automatic pulse();
        @(negedge clk); mag_valid = 1'b1;
        @(negedge clk); mag_valid = 1'b0;
    endtask

    task automatic wait_done(input int start, input bit chk_lat);
        int cyc, bcnt;
        bit seen;
        cyc = start; bcnt = 0; seen = 1'b0;
        while (!seen && cyc < 40) begin
            if (busy) bcnt++;
            if (frame_done) seen = 1'b1;
            else begin @(negedge clk); cyc++; end
        end
        check("frame_done_seen", int'(seen), 1);
        if (chk_lat) begin
            check("latency", cyc, NB + 1);
            check("busy_cycles", bcnt, NB + 1);
        end
        @(negedge clk);
        check("busy_after_done", int'(busy), 0);
    endtask

    task automatic send_frame(input bit chk_lat);
        model_push();
        pulse();
        wait_done(1, chk_lat);
    endtask

    initial begin
        int prev, d0;
        set_all(0);
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Idle after reset: everything zero, no frame_done.
        repeat (20) begin
            @(negedge clk);
            if (busy || frame_done) check("idle_quiet", int'({busy, frame_done}), 0);
        end
        check("idle_done_cnt", done_cnt, 0);
        check("idle_busy", int'(busy), 0);
        check("idle_max_bin", int'(max_bin), 0);
        check("idle_max_mag", int'(max_mag), 0);
        check("idle_smooth0", int'(smooth[0]), 0);
        check("idle_peak7", int'(peak[7]), 0);
`ifdef SPECTRUM_OVERRUN_CNT_EN
        check("idle_overrun", int'(overrun_cnt), 0);
`endif

        // Flat frame of 1000: latency, tie rule and first-step values.
        set_all(1000);
        send_frame(1'b1);
        for (int i = 0; i < NB; i++) begin
            check("t2_smooth", int'(smooth[i]), 62);
            check("t2_peak", int'(peak[i]), 1000);
        end
        check("t2_max_bin", int'(max_bin), 0);
        check("t2_max_mag", int'(max_mag), 1000);

        // Isolated peak in bin 3, then held for 16 frames before decaying.
        set_all(0); mag[3] = MW'(4000);
        send_frame(1'b0);
        set_all(0);
        for (int j = 1; j <= 17; j++) begin
            send_frame(1'b0);
            if (j == 16) check("t3_peak_held", int'(peak[3]), 4000);
            if (j == 17) check("t3_peak_decay", int'(peak[3]), 3750);
        end
        check("t3_max_mag", int'(max_mag), 0);

        // Full-scale bin 5 held constant: monotonic exact convergence.
        set_all(0); mag[5] = MW'(8191);
        prev = int'(smooth[5]);
        for (int j = 0; j < 200; j++) begin
            send_frame(1'b0);
            if (int'(smooth[5]) < prev) check("t4_monotonic", int'(smooth[5]), prev);
            prev = int'(smooth[5]);
        end
        check("t4_final_smooth", int'(smooth[5]), 8191);
        check("t4_max_bin", int'(max_bin), 5);

        // Second strobe 3 cycles into the frame must be ignored.
        set_all(100); mag[2] = MW'(700);
        model_push();
        pulse();
        @(negedge clk); @(negedge clk);
        set_all(5000); mag_valid = 1'b1;
        @(negedge clk); mag_valid = 1'b0;
        wait_done(4, 1'b0);
        check("t5_max_bin", int'(max_bin), 2);
        check("t5_max_mag", int'(max_mag), 700);
        check("t5_sb_drained", sb.size(), 0);
        check("t5_done_cnt", done_cnt, 1 + 1 + 17 + 200 + 1);
`ifdef SPECTRUM_OVERRUN_CNT_EN
        check("t5_overrun", int'(overrun_cnt), 1);
`endif

        // Reset mid-scan at idx 4: immediate clear, no frame_done.
        d0 = done_cnt;
        set_all(3000);
        model_push();
        pulse();
        repeat (4) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("t6_busy", int'(busy), 0);
        check("t6_frame_done", int'(frame_done), 0);
        check("t6_max_bin", int'(max_bin), 0);
        check("t6_max_mag", int'(max_mag), 0);
        for (int i = 0; i < NB; i++) begin
            check("t6_smooth", int'(smooth[i]), 0);
            check("t6_peak", int'(peak[i]), 0);
        end
`ifdef SPECTRUM_OVERRUN_CNT_EN
        check("t6_overrun", int'(overrun_cnt), 0);
`endif
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_no_done", done_cnt, d0);
        set_all(500);
        send_frame(1'b1);
        check("t6_smooth_after", int'(smooth[0]), 31);
        check("t6_peak_after", int'(peak[7]), 500);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
